// File: rtl/adxl362_ascii_readings_parser.sv
// ============================================================================
// Module   : adxl362_ascii_readings_parser
// Brief    : ASCII "X:hhhh Y:hhhh Z:hhhh T:hhhh" line parser -> 64-bit reading.
//            Optional macro ADXL362_PARSER_LOWERCASE_HEX_EN accepts a-f digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adxl362_ascii_readings_parser #(
  parameter int MAX_LINE_LEN = 32
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rstn_20mhz,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic [63:0] o_3axis_temp,
  output logic        o_reading_valid,
  output logic        o_parse_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLON   = 3'd1,
    S_DIGITS  = 3'd2,
    S_SEP     = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  localparam logic [5:0] c_max_len = 6'(MAX_LINE_LEN);

  // {valid, nibble}
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    hex_val = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      hex_val = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) hex_val = {1'b1, c[3:0] + 4'd9};
`ifdef ADXL362_PARSER_LOWERCASE_HEX_EN
    else if (c >= 8'h61 && c <= 8'h66) hex_val = {1'b1, c[3:0] + 4'd9};
`endif
  endfunction

  // {valid, slot index}: X=0, Y=1, Z=2, T=3
  function automatic logic [2:0] axis_idx(input logic [7:0] c);
    case (c)
      8'h58:   axis_idx = 3'b100;
      8'h59:   axis_idx = 3'b101;
      8'h5A:   axis_idx = 3'b110;
      8'h54:   axis_idx = 3'b111;
      default: axis_idx = 3'b000;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_len, w_len_nxt;
  logic [3:0]  r_mask, w_mask_nxt;
  logic [15:0] r_stage, w_stage_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_axis, w_axis_nxt;
  logic [15:0] r_slot [4];
  logic [63:0] r_temp;
  logic        r_valid, r_error;
  logic        w_valid_nxt, w_error_nxt, w_wr_slot, w_term;
  logic [4:0]  w_hex;
  logic [2:0]  w_ax;

  assign w_term = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
  assign w_hex  = hex_val(i_rx_data);
  assign w_ax   = axis_idx(i_rx_data);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_mask_nxt  = r_mask;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    w_axis_nxt  = r_axis;
    w_wr_slot   = 1'b0;
    w_valid_nxt = 1'b0;
    w_error_nxt = 1'b0;
    if (i_rx_valid) begin
      if (w_term) begin
        if (r_state == S_COLON || r_state == S_DIGITS) begin
          // A terminator inside a field is just another bad byte here.
          w_state_nxt = S_DISCARD;
        end else begin
          if (r_state == S_DISCARD)  w_error_nxt = 1'b1;
          else if (r_mask == 4'hF)   w_valid_nxt = 1'b1;
          else if (r_mask != 4'h0)   w_error_nxt = 1'b1;
          w_state_nxt = S_IDLE;
          w_mask_nxt  = 4'h0;
          w_len_nxt   = 6'd0;
        end
      end else if (r_state != S_DISCARD) begin
        if (r_len == c_max_len) begin
          w_state_nxt = S_DISCARD;
        end else begin
          w_len_nxt = r_len + 6'd1;
          case (r_state)
            S_IDLE: begin
              if (i_rx_data == 8'h20) begin
                w_state_nxt = S_IDLE;
              end else if (w_ax[2] && !r_mask[w_ax[1:0]]) begin
                w_axis_nxt  = w_ax[1:0];
                w_state_nxt = S_COLON;
              end else begin
                w_state_nxt = S_DISCARD;
              end
            end
            S_COLON: begin
              w_cnt_nxt   = 2'd0;
              w_state_nxt = (i_rx_data == 8'h3A) ? S_DIGITS : S_DISCARD;
            end
            S_DIGITS: begin
              if (w_hex[4]) begin
                w_stage_nxt = {r_stage[11:0], w_hex[3:0]};
                w_cnt_nxt   = r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                  w_wr_slot           = 1'b1;
                  w_mask_nxt[r_axis]  = 1'b1;
                  w_state_nxt         = S_SEP;
                end
              end else begin
                w_state_nxt = S_DISCARD;
              end
            end
            S_SEP:   w_state_nxt = (i_rx_data == 8'h20) ? S_IDLE : S_DISCARD;
            default: w_state_nxt = S_DISCARD;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_state <= S_IDLE;
      r_len   <= 6'd0;
      r_mask  <= 4'h0;
      r_stage <= 16'h0;
      r_cnt   <= 2'd0;
      r_axis  <= 2'd0;
      r_temp  <= 64'h0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      for (int i = 0; i < 4; i++) r_slot[i] <= 16'h0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_mask  <= w_mask_nxt;
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
      r_axis  <= w_axis_nxt;
      r_valid <= w_valid_nxt;
      r_error <= w_error_nxt;
      if (w_wr_slot) r_slot[r_axis] <= w_stage_nxt;
      // Byte order is lsb-before-msb per axis in the packed word.
      if (w_valid_nxt)
        r_temp <= {r_slot[0][7:0], r_slot[0][15:8], r_slot[1][7:0], r_slot[1][15:8],
                   r_slot[2][7:0], r_slot[2][15:8], r_slot[3][7:0], r_slot[3][15:8]};
    end
  end

  assign o_3axis_temp    = r_temp;
  assign o_reading_valid = r_valid;
  assign o_parse_error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_adxl362_ascii_readings_parser.sv
// ============================================================================
// Module   : tb_adxl362_ascii_readings_parser
// Brief    : Table-driven bench with a per-terminator expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adxl362_ascii_readings_parser;

  typedef struct {
    string       name;
    string       line;
    string       term;
    logic        exp_valid;
    logic        exp_error;
    logic [63:0] word;
  } vec_t;

  typedef struct {
    string       name;
    logic        valid;
    logic        error;
    logic [63:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [63:0] temp;
  logic        rd_valid;
  logic        perr;
  logic        term_d;

  int          checks;
  int          errors;
  logic [63:0] last_word;
  exp_t        sb[$];
  vec_t        vecs[$];

  adxl362_ascii_readings_parser #(.MAX_LINE_LEN(32)) dut (
    .i_clk_20mhz     (clk),
    .i_rstn_20mhz    (rst_n),
    .i_rx_valid      (rx_valid),
    .i_rx_data       (rx_data),
    .o_3axis_temp    (temp),
    .o_reading_valid (rd_valid),
    .o_parse_error   (perr)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Marks the cycle after a terminator was sampled by the DUT.
  always @(posedge clk)
    term_d <= rst_n && rx_valid && (rx_data == 8'h0D || rx_data == 8'h0A);

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (term_d) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: pulse valid=%b err=%b with no expectation", rd_valid, perr);
        end else begin
          e = sb.pop_front();
          if (rd_valid !== e.valid || perr !== e.error || temp !== e.word) begin
            errors++;
            $display("FAIL %s: got valid=%b err=%b word=%h, expected valid=%b err=%b word=%h",
                     e.name, rd_valid, perr, temp, e.valid, e.error, e.word);
          end
        end
      end else if (rd_valid !== 1'b0 || perr !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%b err=%b, expected none", rd_valid, perr);
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    idle_cycles(int'($urandom_range(0, max_gap)));
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic push_exp(input string n, input logic v, input logic er, input logic [63:0] w);
    exp_t e;
    if (v) last_word = w;
    e.name  = n;
    e.valid = v;
    e.error = er;
    e.word  = last_word;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    for (int k = 0; k < v.line.len(); k++) send_byte(v.line[k], 2);
    for (int j = 0; j < v.term.len(); j++) begin
      if (j == 0) push_exp(v.name, v.exp_valid, v.exp_error, v.word);
      else        push_exp({v.name, "_extra_term"}, 1'b0, 1'b0, 64'h0);
      send_byte(v.term[j], 0);
    end
    idle_cycles(2);
  endtask

  task automatic add(input string n, input string l, input string t,
                     input logic v, input logic er, input logic [63:0] w);
    vec_t x;
    x.name = n; x.line = l; x.term = t; x.exp_valid = v; x.exp_error = er; x.word = w;
    vecs.push_back(x);
  endtask

  initial begin
    string sp40, ln32, ln33;
    checks    = 0;
    errors    = 0;
    last_word = 64'h0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rst_n     = 1'b0;

    sp40 = "";
    for (int i = 0; i < 40; i++) sp40 = {sp40, " "};
    ln32 = "X:0001 Y:0002 Z:0003 T:0004     ";
    ln33 = "X:0001 Y:0002 Z:0003 T:0004      ";

    add("basic",       "X:0123  Y:ABCD  Z:0FF0  T:0210", "\r",   1, 0, 64'h2301_CDAB_F00F_1002);
    add("reorder_crlf","T:1111 Z:2222 Y:3333 X:4444",    "\r\n", 1, 0, 64'h4444_3333_2222_1111);
    add("bad_digit",   "X:012G Y:0000 Z:0000 T:0000",    "\n",   0, 1, 64'h0);
    add("dup_axis",    "X:0001 X:0002 Y:0000 Z:0000",    "\r",   0, 1, 64'h0);
    add("missing",     "X:0001",                         "\r",   0, 1, 64'h0);
    add("too_long",    sp40,                             "\r",   0, 1, 64'h0);
    add("len_32_ok",   ln32,                             "\r",   1, 0, 64'h0100_0200_0300_0400);
    add("len_33_bad",  ln33,                             "\r",   0, 1, 64'h0);
    add("empty",       "",                               "\r",   0, 0, 64'h0);
    add("lower_axis",  "x:0001 Y:0000 Z:0000 T:0000",    "\r",   0, 1, 64'h0);
    add("spaces",      "  Z:FFFF X:8000 T:0001 Y:00FF  ", "\n",  1, 0, 64'h0080_FF00_FFFF_0100);
    add("no_colon",    "X0123 Y:0000 Z:0000 T:0000",     "\r",   0, 1, 64'h0);
    add("no_sep",      "X:0123Y:0000 Z:0000 T:0000",     "\r",   0, 1, 64'h0);
`ifdef ADXL362_PARSER_LOWERCASE_HEX_EN
    add("lower_hex",   "X:00ab Y:0000 Z:0000 T:0000",    "\r",   1, 0, 64'hAB00_0000_0000_0000);
`else
    add("lower_hex",   "X:00ab Y:0000 Z:0000 T:0000",    "\r",   0, 1, 64'h0);
`endif

    idle_cycles(3);
    @(negedge clk);
    checks++; if (temp !== 64'h0) begin errors++; $display("FAIL reset_word: got %h expected %h", temp, 64'h0); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", perr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset mid-field, then a clean line must produce one fresh reading.
    send_byte("X", 0); send_byte(":", 0); send_byte("0", 0); send_byte("1", 0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    last_word = 64'h0;
    @(negedge clk);
    checks++; if (temp !== 64'h0) begin errors++; $display("FAIL midreset_word: got %h expected %h", temp, 64'h0); end
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(3);
    begin
      vec_t v;
      v.name = "after_reset"; v.line = "23 Y:5678 Z:9ABC T:DEF0"; v.term = "\r";
      v.exp_valid = 0; v.exp_error = 1; v.word = 64'h0;
      run_vec(v);
      v.name = "clean_after_reset"; v.line = "X:1234 Y:5678 Z:9ABC T:DEF0";
      v.exp_valid = 1; v.exp_error = 0; v.word = 64'h3412_7856_BC9A_F0DE;
      run_vec(v);
    end

    idle_cycles(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
